mips_run_ctrl: RTL and testbench
================================

Name: mips_run_ctrl

Overview:
- Parametrised execution controller for the 5-stage MIPS pipeline. It replaces the ad-hoc halt/stop OR-ing at the top level.
- Drives one pipeline-wide freeze (o_halt) to all stages (IF, ID, EX, MEM).
- Supports three run modes: continuous, single-step, and N-step burst.
- On a decoded HALT instruction it drains the pipeline for a configurable depth before reporting done.
- Counts executed (unfrozen) cycles for the debug unit.

Parameters:
- NB_CYCLE, 32, width of the executed-cycle counter.
- NB_STEP, 16, width of the N-step burst count.
- PIPE_DEPTH, 4, number of unfrozen cycles after i_stop, so that in-flight instructions reach WB. Legal range 1..15.

Ports:
- clk  in  1  system clock.
- i_rst  in  1  synchronous, active-high reset.
- i_load_done  in  1  instruction memory loaded; i_start is ignored while low.
- i_mode  in  2  run mode: 00 continuous, 01 single-step, 10 N-step, 11 reserved (treated as continuous).
- i_start  in  1  one-cycle pulse to begin execution from IDLE.
- i_step  in  1  one-cycle pulse to advance one cycle while in STEP_WAIT.
- i_nsteps  in  NB_STEP  burst length; sampled on i_start in N-step mode, and on i_step in STEP_WAIT when i_mode=10.
- i_stop  in  1  HALT instruction decoded in ID (the ID stop flag).
- i_abort  in  1  force return to IDLE.
- i_clear  in  1  DONE/IDLE to IDLE, and clear the cycle counter.
- o_halt  out  1  pipeline freeze, 1 = all stages hold.
- o_running  out  1  high in RUN, STEP_EXEC, DRAIN.
- o_step_ack  out  1  one-cycle pulse in each STEP_EXEC cycle.
- o_done  out  1  high in DONE.
- o_state  out  3  encoded state for the debug unit.
- o_cycle_count  out  NB_CYCLE  number of cycles with o_halt=0 since last clear.

Behaviour:
- Moore outputs: o_halt, o_running, o_done and o_state decode the state register directly, with no registered lag.
- Reset values:
  - state=IDLE, so o_halt=1 and o_running=0, o_done=0, o_step_ack=0.
  - o_cycle_count=0; remaining-step counter=0; drain counter=0.
- State encodings: IDLE=0, RUN=1, STEP_WAIT=2, STEP_EXEC=3, DRAIN=4, DONE=5.
- IDLE: o_halt=1.
  - i_start & i_load_done, mode 00/11: go to RUN, unlimited.
  - i_start & i_load_done, mode 01: go to STEP_WAIT.
  - i_start & i_load_done, mode 10: load remaining=i_nsteps. If i_nsteps=0, go to STEP_WAIT; otherwise go to RUN, limited.
- RUN: o_halt=0; count increments each cycle.
  - i_stop: go to DRAIN and load drain=PIPE_DEPTH.
  - Else if limited and remaining==1: go to STEP_WAIT.
  - Limited mode decrements remaining each cycle.
  - So an N-step burst gives exactly N unfrozen cycles.
- STEP_WAIT: o_halt=1.
  - i_step with i_mode=01: go to STEP_EXEC.
  - i_step with i_mode=10 and i_nsteps>0: reload remaining and go to RUN, limited.
  - i_step with i_mode=10 and i_nsteps=0: treated as single step.
- STEP_EXEC: exactly one cycle with o_halt=0; o_step_ack=1; count increments.
  - Next state is DRAIN if i_stop, else STEP_WAIT.
  - i_step during STEP_EXEC is ignored, not queued.
- DRAIN: o_halt=0 for exactly PIPE_DEPTH cycles; count increments; drain decrements.
  - When drain==1, go to DONE.
  - i_stop is ignored, as are step and mode inputs.
  - The drain runs unfrozen even if entered from single-step.
- DONE: o_halt=1, o_done=1.
  - i_clear: go to IDLE and clear the count.
  - i_start is ignored.
- Priority: i_rst > i_abort > i_clear > i_stop > step/burst expiry > i_start/i_step.
  - i_abort in any state: go to IDLE; count retained; remaining and drain zeroed.
  - i_clear outside IDLE/DONE is ignored.
  - i_stop and burst expiry in the same RUN cycle: DRAIN wins.
- Counter rules:
  - o_cycle_count saturates at all-ones; it does not wrap.
  - remaining and drain are unsigned and never decrement below 0.
- Reset mid-operation returns to IDLE in the next cycle, with all counters zeroed.

Decomposition:
- Shared package mips_pkg holds:
  - state encodings (localparams ST_IDLE..ST_DONE);
  - mode encodings (MODE_CONT=2'b00, MODE_STEP=2'b01, MODE_NSTEP=2'b10);
  - default PIPE_DEPTH=4.
- One sub-module is natural: sat_counter (parametrised width, enable, clear, saturating), used for o_cycle_count.
- The remaining and drain counters are inline.

Test Plan:
- Reset, then i_mode=00 and i_start, with i_stop asserted 10 cycles later: expect o_halt=0 for 10+4 cycles, then o_done=1, o_cycle_count=14, o_halt=1.
- i_mode=10, i_nsteps=5, i_start: expect exactly 5 cycles with o_halt=0, then state=STEP_WAIT and count=5. Then i_step with i_nsteps=3: expect 3 more cycles, count=8.
- i_mode=01, three i_step pulses 4 cycles apart: expect three single-cycle o_halt=0 windows, each with o_step_ack=1, and count=3. A second i_step inside STEP_EXEC gives no extra cycle.
- N-step with i_nsteps=4, and i_stop on the 4th unfrozen cycle: expect DRAIN (not STEP_WAIT), DONE after 4 more cycles, count=8.
- i_abort during DRAIN (cycle 2 of 4): expect IDLE next cycle, o_done=0, count retained. Then i_clear: count=0.
- i_start with i_load_done=0: state remains IDLE. Force count to 2^NB_CYCLE-2 with continuous RUN for 5 cycles: expect count saturated at all-ones. Asserting i_rst mid-RUN gives IDLE, count=0.

Source files
------------

// File: rtl/mips_run_ctrl_pkg.sv
// rtl/mips_run_ctrl_pkg.sv - state/mode encodings shared by the MIPS run controller
package mips_pkg;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_RUN       = 3'd1;
   localparam logic [2:0] ST_STEP_WAIT = 3'd2;
   localparam logic [2:0] ST_STEP_EXEC = 3'd3;
   localparam logic [2:0] ST_DRAIN     = 3'd4;
   localparam logic [2:0] ST_DONE      = 3'd5;

   localparam logic [1:0] MODE_CONT  = 2'b00;
   localparam logic [1:0] MODE_STEP  = 2'b01;
   localparam logic [1:0] MODE_NSTEP = 2'b10;

   localparam int DEF_PIPE_DEPTH = 4;

   typedef enum logic [2:0] {
      S_IDLE      = ST_IDLE,
      S_RUN       = ST_RUN,
      S_STEP_WAIT = ST_STEP_WAIT,
      S_STEP_EXEC = ST_STEP_EXEC,
      S_DRAIN     = ST_DRAIN,
      S_DONE      = ST_DONE
   } state_e;

   // The pipeline advances only in these states; everything else freezes it.
   function automatic logic is_unfrozen(input state_e s);
      return (s == S_RUN) || (s == S_STEP_EXEC) || (s == S_DRAIN);
   endfunction

endpackage

// File: rtl/mips_run_ctrl_if.sv
// rtl/mips_run_ctrl_if.sv - control/status bundle between debug unit and run controller
interface mips_run_ctrl_if #(
   parameter int NB_CYCLE = 32,
   parameter int NB_STEP  = 16
);
   logic                i_load_done;
   logic [1:0]          i_mode;
   logic                i_start;
   logic                i_step;
   logic [NB_STEP-1:0]  i_nsteps;
   logic                i_stop;
   logic                i_abort;
   logic                i_clear;
   logic                o_halt;
   logic                o_running;
   logic                o_step_ack;
   logic                o_done;
   logic [2:0]          o_state;
   logic [NB_CYCLE-1:0] o_cycle_count;

   modport master (
      output i_load_done, i_mode, i_start, i_step, i_nsteps, i_stop, i_abort, i_clear,
      input  o_halt, o_running, o_step_ack, o_done, o_state, o_cycle_count
   );

   modport slave (
      input  i_load_done, i_mode, i_start, i_step, i_nsteps, i_stop, i_abort, i_clear,
      output o_halt, o_running, o_step_ack, o_done, o_state, o_cycle_count
   );
endinterface

// File: rtl/mips_run_ctrl_sat_counter.sv
// rtl/mips_run_ctrl_sat_counter.sv - saturating up-counter with clear
module sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [WIDTH-1:0] cnt_o
);
   logic [WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i && (cnt_q != '1))
         cnt_d = cnt_q + WIDTH'(1);
   end

   always_ff @(posedge clk) begin
      if (rst_i)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;
endmodule

// File: rtl/mips_run_ctrl.sv
// rtl/mips_run_ctrl.sv - run/step/burst/drain controller driving the pipeline-wide freeze
module mips_run_ctrl
   import mips_pkg::*;
#(
   parameter int NB_CYCLE   = 32,
   parameter int NB_STEP    = 16,
   parameter int PIPE_DEPTH = DEF_PIPE_DEPTH
) (
   input  logic           clk,
   input  logic           i_rst,
   mips_run_ctrl_if.slave bus
);
   state_e             state_q, state_d;
   logic [NB_STEP-1:0] rem_q, rem_d;
   logic [3:0]         drain_q, drain_d;
   logic               lim_q, lim_d;
   logic               cnt_clr;

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      drain_d = drain_q;
      lim_d   = lim_q;
      cnt_clr = 1'b0;
      if (bus.i_abort) begin
         state_d = S_IDLE;
         rem_d   = '0;
         drain_d = '0;
         lim_d   = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.i_clear) begin
                  cnt_clr = 1'b1;
               end else if (bus.i_start && bus.i_load_done) begin
                  if (bus.i_mode == MODE_STEP) begin
                     state_d = S_STEP_WAIT;
                  end else if (bus.i_mode == MODE_NSTEP) begin
                     rem_d   = bus.i_nsteps;
                     lim_d   = (bus.i_nsteps != '0);
                     state_d = (bus.i_nsteps != '0) ? S_RUN : S_STEP_WAIT;
                  end else begin
                     lim_d   = 1'b0;
                     state_d = S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (lim_q && (rem_q != '0))
                  rem_d = rem_q - NB_STEP'(1);
               if (bus.i_stop) begin
                  state_d = S_DRAIN;
                  drain_d = 4'(PIPE_DEPTH);
               end else if (lim_q && (rem_q == NB_STEP'(1))) begin
                  state_d = S_STEP_WAIT;
               end
            end
            S_STEP_WAIT: begin
               if (bus.i_step) begin
                  if ((bus.i_mode == MODE_NSTEP) && (bus.i_nsteps != '0)) begin
                     rem_d   = bus.i_nsteps;
                     lim_d   = 1'b1;
                     state_d = S_RUN;
                  end else if ((bus.i_mode == MODE_STEP) || (bus.i_mode == MODE_NSTEP)) begin
                     state_d = S_STEP_EXEC;
                  end
               end
            end
            S_STEP_EXEC: begin
               if (bus.i_stop) begin
                  state_d = S_DRAIN;
                  drain_d = 4'(PIPE_DEPTH);
               end else begin
                  state_d = S_STEP_WAIT;
               end
            end
            S_DRAIN: begin
               if (drain_q != '0)
                  drain_d = drain_q - 4'd1;
               // A zero drain count can only come from corruption; finish rather than stall.
               if (drain_q <= 4'd1)
                  state_d = S_DONE;
            end
            S_DONE: begin
               if (bus.i_clear) begin
                  cnt_clr = 1'b1;
                  state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         rem_q   <= '0;
         drain_q <= '0;
         lim_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         drain_q <= drain_d;
         lim_q   <= lim_d;
      end
   end

   sat_counter #(.WIDTH(NB_CYCLE)) u_cycle_cnt (
      .clk   (clk),
      .rst_i (i_rst),
      .clr_i (cnt_clr),
      .en_i  (is_unfrozen(state_q)),
      .cnt_o (bus.o_cycle_count)
   );

   assign bus.o_halt     = !is_unfrozen(state_q);
   assign bus.o_running  = is_unfrozen(state_q);
   assign bus.o_step_ack = (state_q == S_STEP_EXEC);
   assign bus.o_done     = (state_q == S_DONE);
   assign bus.o_state    = state_q;
endmodule

// File: tb/tb_mips_run_ctrl.sv
// tb/tb_mips_run_ctrl.sv - directed bench for mips_run_ctrl with a cycle-level reference model
module tb_mips_run_ctrl;
   logic        clk;
   logic        t_rst, t_load_done, t_start, t_step, t_stop, t_abort, t_clear;
   logic [1:0]  t_mode;
   logic [15:0] t_nsteps;
   int          total = 0;
   int          bad = 0;
   bit          chk_on = 0;

   mips_run_ctrl_if #(.NB_CYCLE(32), .NB_STEP(16)) bus0 ();
   mips_run_ctrl_if #(.NB_CYCLE(3),  .NB_STEP(16)) bus1 ();

   mips_run_ctrl #(.NB_CYCLE(32), .NB_STEP(16), .PIPE_DEPTH(4)) dut0 (.clk(clk), .i_rst(t_rst), .bus(bus0));
   mips_run_ctrl #(.NB_CYCLE(3),  .NB_STEP(16), .PIPE_DEPTH(1)) dut1 (.clk(clk), .i_rst(t_rst), .bus(bus1));

   assign bus0.i_load_done = t_load_done;  assign bus1.i_load_done = t_load_done;
   assign bus0.i_mode      = t_mode;       assign bus1.i_mode      = t_mode;
   assign bus0.i_start     = t_start;      assign bus1.i_start     = t_start;
   assign bus0.i_step      = t_step;       assign bus1.i_step      = t_step;
   assign bus0.i_nsteps    = t_nsteps;     assign bus1.i_nsteps    = t_nsteps;
   assign bus0.i_stop      = t_stop;       assign bus1.i_stop      = t_stop;
   assign bus0.i_abort     = t_abort;      assign bus1.i_abort     = t_abort;
   assign bus0.i_clear     = t_clear;      assign bus1.i_clear     = t_clear;

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: phase numbers are the published debug encodings; 'left' is unfrozen cycles still owed.
   int     m_ph[2]   = '{0, 0};
   int     m_left[2] = '{0, 0};
   bit     m_lim[2]  = '{0, 0};
   longint m_cnt[2]  = '{0, 0};
   longint m_max[2]  = '{64'hFFFF_FFFF, 7};
   int     m_dep[2]  = '{4, 1};

   function automatic bit active(input int ph);
      return (ph == 1) || (ph == 3) || (ph == 4);
   endfunction

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (t_rst) begin
            m_ph[k] = 0; m_left[k] = 0; m_cnt[k] = 0; m_lim[k] = 0;
         end else begin
            if (!t_abort && t_clear && (m_ph[k] == 0 || m_ph[k] == 5)) m_cnt[k] = 0;
            else if (active(m_ph[k]) && m_cnt[k] < m_max[k]) m_cnt[k]++;
            if (t_abort) begin
               m_ph[k] = 0; m_left[k] = 0; m_lim[k] = 0;
            end else begin
               case (m_ph[k])
                  0: if (!t_clear && t_start && t_load_done) begin
                        if (t_mode == 1) m_ph[k] = 2;
                        else if (t_mode == 2) begin
                           if (t_nsteps == 0) m_ph[k] = 2;
                           else begin m_ph[k] = 1; m_lim[k] = 1; m_left[k] = t_nsteps; end
                        end else begin m_ph[k] = 1; m_lim[k] = 0; end
                     end
                  1: if (t_stop) begin m_ph[k] = 4; m_left[k] = m_dep[k]; end
                     else if (m_lim[k]) begin
                        m_left[k]--;
                        if (m_left[k] == 0) m_ph[k] = 2;
                     end
                  2: if (t_step) begin
                        if (t_mode == 2 && t_nsteps != 0) begin m_ph[k] = 1; m_lim[k] = 1; m_left[k] = t_nsteps; end
                        else if (t_mode == 1 || t_mode == 2) m_ph[k] = 3;
                     end
                  3: if (t_stop) begin m_ph[k] = 4; m_left[k] = m_dep[k]; end
                     else m_ph[k] = 2;
                  4: begin m_left[k]--; if (m_left[k] == 0) m_ph[k] = 5; end
                  5: if (t_clear) m_ph[k] = 0;
                  default: m_ph[k] = 0;
               endcase
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         chk("state0",   bus0.o_state,         m_ph[0]);
         chk("halt0",    bus0.o_halt,          !active(m_ph[0]));
         chk("running0", bus0.o_running,       active(m_ph[0]));
         chk("ack0",     bus0.o_step_ack,      m_ph[0] == 3);
         chk("done0",    bus0.o_done,          m_ph[0] == 5);
         chk("count0",   bus0.o_cycle_count,   m_cnt[0]);
         chk("state1",   bus1.o_state,         m_ph[1]);
         chk("halt1",    bus1.o_halt,          !active(m_ph[1]));
         chk("done1",    bus1.o_done,          m_ph[1] == 5);
         chk("count1",   bus1.o_cycle_count,   m_cnt[1]);
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic pulse_start();
      t_start = 1; wait_cyc(1); t_start = 0;
   endtask

   task automatic pulse_clear();
      t_clear = 1; wait_cyc(1); t_clear = 0;
   endtask

   task automatic pulse_abort();
      t_abort = 1; wait_cyc(1); t_abort = 0;
   endtask

   initial begin
      t_rst = 1; t_load_done = 1; t_mode = 0; t_start = 0; t_step = 0;
      t_nsteps = 0; t_stop = 0; t_abort = 0; t_clear = 0;
      wait_cyc(2);
      chk_on = 1;
      t_rst = 0;
      chk("rst_state", bus0.o_state, 0);
      chk("rst_halt",  bus0.o_halt, 1);
      chk("rst_count", bus0.o_cycle_count, 0);

      // continuous run, stop after 10 unfrozen cycles, 4-cycle drain
      t_mode = 2'b00;
      pulse_start();
      wait_cyc(9);
      t_stop = 1; wait_cyc(1); t_stop = 0;
      chk("cont_drain_state", bus0.o_state, 4);
      wait_cyc(4);
      chk("cont_done",  bus0.o_done, 1);
      chk("cont_count", bus0.o_cycle_count, 14);
      chk("cont_halt",  bus0.o_halt, 1);
      pulse_start();
      chk("done_ignores_start", bus0.o_state, 5);
      pulse_clear();
      chk("clear_state", bus0.o_state, 0);
      chk("clear_count", bus0.o_cycle_count, 0);

      // N-step burst of 5 then 3
      t_mode = 2'b10; t_nsteps = 5;
      pulse_start();
      wait_cyc(5);
      chk("burst5_state", bus0.o_state, 2);
      chk("burst5_count", bus0.o_cycle_count, 5);
      t_nsteps = 3;
      t_step = 1; wait_cyc(1); t_step = 0;
      wait_cyc(3);
      chk("burst3_state", bus0.o_state, 2);
      chk("burst3_count", bus0.o_cycle_count, 8);
      pulse_abort();
      pulse_clear();

      // single-step: three steps, the first held into STEP_EXEC
      t_mode = 2'b01;
      pulse_start();
      for (int i = 0; i < 3; i++) begin
         t_step = 1; wait_cyc(1);
         chk("step_ack", bus0.o_step_ack, 1);
         chk("step_halt", bus0.o_halt, 0);
         if (i != 0) t_step = 0;
         wait_cyc(1);
         t_step = 0;
         wait_cyc(2);
      end
      chk("step_count", bus0.o_cycle_count, 3);
      chk("step_state", bus0.o_state, 2);
      pulse_abort();
      pulse_clear();

      // stop coincides with burst expiry: drain wins
      t_mode = 2'b10; t_nsteps = 4;
      pulse_start();
      wait_cyc(3);
      t_stop = 1; wait_cyc(1); t_stop = 0;
      chk("stop_vs_expiry", bus0.o_state, 4);
      wait_cyc(4);
      chk("stop_exp_done",  bus0.o_done, 1);
      chk("stop_exp_count", bus0.o_cycle_count, 8);
      pulse_clear();

      // abort in the second drain cycle
      t_mode = 2'b00;
      pulse_start();
      wait_cyc(2);
      t_stop = 1; wait_cyc(1); t_stop = 0;
      wait_cyc(1);
      pulse_abort();
      chk("abort_state", bus0.o_state, 0);
      chk("abort_done",  bus0.o_done, 0);
      chk("abort_count", bus0.o_cycle_count, 5);
      pulse_clear();
      chk("abort_clear_count", bus0.o_cycle_count, 0);

      // start without load_done, then mode 11 run, saturation, reset mid-run
      t_load_done = 0;
      pulse_start();
      chk("noload_state", bus0.o_state, 0);
      t_load_done = 1; t_mode = 2'b11;
      pulse_start();
      wait_cyc(10);
      chk("sat_count_small", bus1.o_cycle_count, 7);
      chk("run_count", bus0.o_cycle_count, 10);
      pulse_clear();
      chk("clear_in_run_state", bus0.o_state, 1);
      chk("clear_in_run_count", bus0.o_cycle_count, 11);
      t_rst = 1; wait_cyc(1); t_rst = 0;
      chk("midrst_state", bus0.o_state, 0);
      chk("midrst_count", bus0.o_cycle_count, 0);
      wait_cyc(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
